// File: rtl/cmd_icd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cmd_icd_pkg
// Description : Shared command-word layout, bank sizing and reserved-bit checks
//               for the command dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
package cmd_icd_pkg;

  localparam int NUM_BANKS  = 4;
  localparam int BANK_VAL_W = 8;

  localparam logic [3:0] ID_BANK = 4'b0000;
  localparam logic [3:0] ID_OUT  = 4'b0001;

  // BANK view: [27:16] reserved, [15:8] value, [7:4] reserved, [3:0] enable
  typedef struct packed {
    logic [11:0]           rsvd_hi;
    logic [BANK_VAL_W-1:0] val;
    logic [3:0]            rsvd_lo;
    logic [NUM_BANKS-1:0]  en;
  } bank_body_t;

  // OUT view: [27:5] reserved, [4:0] output code
  typedef struct packed {
    logic [22:0] rsvd;
    logic [4:0]  code;
  } out_body_t;

  typedef union packed {
    bank_body_t  bank;
    out_body_t   out;
    logic [27:0] raw;
  } cmd_body_t;

  typedef struct packed {
    logic [3:0] id;
    cmd_body_t  body;
  } cmd_word_t;

  // A BANK word is only legal with every reserved bit clear
  function automatic logic bank_word_ok(input cmd_word_t w);
    return (w.id == ID_BANK) && (w.body.bank.rsvd_hi == '0) &&
           (w.body.bank.rsvd_lo == '0);
  endfunction

  // An OUT word is only legal with every reserved bit clear
  function automatic logic out_word_ok(input cmd_word_t w);
    return (w.id == ID_OUT) && (w.body.out.rsvd == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_word_decode.sv
`default_nettype none
// ============================================================================
// Module      : cmd_word_decode
// Description : Pure combinational classifier for a 32-bit command word.
//               Exactly one of is_bank/is_out/is_err is high.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_word_decode
  import cmd_icd_pkg::*;
(
  input  logic [31:0]           word_i,
  output logic                  is_bank_o,
  output logic                  is_out_o,
  output logic                  is_err_o,
  output logic [NUM_BANKS-1:0]  en_o,
  output logic [BANK_VAL_W-1:0] val_o,
  output logic [4:0]            code_o
);

  cmd_word_t w_word;

  assign w_word    = word_i;
  assign is_bank_o = bank_word_ok(w_word);
  assign is_out_o  = out_word_ok(w_word);
  assign is_err_o  = ~(is_bank_o | is_out_o);
  assign en_o      = w_word.body.bank.en;
  assign val_o     = w_word.body.bank.val;
  assign code_o    = w_word.body.out.code;

endmodule
`default_nettype wire

// File: rtl/cmd_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : cmd_dispatcher
// Description : Accepts command words one at a time, writes bank registers,
//               issues output codes with a valid/ready handshake and counts
//               malformed words with a saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_dispatcher
  import cmd_icd_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [31:0]                     cmd_word,
  output logic [NUM_BANKS*BANK_VAL_W-1:0] bank_val,
  output logic [NUM_BANKS-1:0]            bank_upd,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [4:0]                      out_code,
  output logic                            err_pulse,
  output logic [ERR_CNT_W-1:0]            err_cnt,
  output logic                            busy
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EXEC     = 2'd1,
    ST_OUT_WAIT = 2'd2
  } state_t;

  state_t                  state_q;
  logic [31:0]             cmd_q;
  logic [BANK_VAL_W-1:0]   bank_q [NUM_BANKS];
  logic [NUM_BANKS-1:0]    bank_upd_q;
  logic                    out_valid_q;
  logic [4:0]              out_code_q;
  logic                    err_pulse_q;
  logic [ERR_CNT_W-1:0]    err_cnt_q;
  logic [ERR_CNT_W-1:0]    err_cnt_d;

  logic                    dec_is_bank;
  logic                    dec_is_out;
  logic                    dec_is_err;
  logic [NUM_BANKS-1:0]    dec_en;
  logic [BANK_VAL_W-1:0]   dec_val;
  logic [4:0]              dec_code;

  // Decode always looks at the latched word, never the live input
  cmd_word_decode u_decode (
    .word_i    (cmd_q),
    .is_bank_o (dec_is_bank),
    .is_out_o  (dec_is_out),
    .is_err_o  (dec_is_err),
    .en_o      (dec_en),
    .val_o     (dec_val),
    .code_o    (dec_code)
  );

  // Error counter sticks at all-ones once saturated
  assign err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + ERR_CNT_W'(1);

  // Sequencer: accept, execute for one cycle, optionally wait on the output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      for (int i = 0; i < NUM_BANKS; i++) bank_q[i] <= '0;
      bank_upd_q  <= '0;
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      bank_upd_q  <= '0;
      err_pulse_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_q   <= cmd_word;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (dec_is_bank) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
              if (dec_en[i]) bank_q[i] <= dec_val;
            end
            bank_upd_q <= dec_en;
            state_q    <= ST_IDLE;
          end else if (dec_is_out) begin
            out_code_q  <= dec_code;
            out_valid_q <= 1'b1;
            state_q     <= ST_OUT_WAIT;
          end else if (dec_is_err) begin
            err_pulse_q <= 1'b1;
            err_cnt_q   <= err_cnt_d;
            state_q     <= ST_IDLE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_OUT_WAIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Flatten the bank array onto the output bus, bank i at [8i+7:8i]
  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank_out
    assign bank_val[g*BANK_VAL_W +: BANK_VAL_W] = bank_q[g];
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign bank_upd  = bank_upd_q;
  assign out_valid = out_valid_q;
  assign out_code  = out_code_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;

endmodule
`default_nettype wire

// File: doc/cmd_dispatcher.md
# cmd_dispatcher

Sequencer that accepts 32-bit command words on a valid/ready stream and executes them one at a time. It decodes the 4-bit command ID. BANK commands update four 8-bit bank value registers under an enable mask. OUT commands issue a 5-bit output code to the downstream output stage with a valid/ready handshake. The block sits between the command parser front end and the bank/output datapath; malformed words are rejected and counted.

## Interface
- ERR_CNT_W, 8, width of saturating error counter
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- cmd_valid  in  1  command word valid
- cmd_ready  out  1  dispatcher can accept a word
- cmd_word  in  32  command word; ID in [31:28]
- bank_val  out  4x8 (32)  bank registers, bank i at [8i+7:8i]
- bank_upd  out  4  one-cycle pulse per bank written
- out_valid  out  1  output code valid
- out_ready  in  1  downstream accepts code
- out_code  out  5  code from OUT command [4:0]
- err_pulse  out  1  one-cycle pulse on rejected word
- err_cnt  out  ERR_CNT_W  rejected-word count, saturating
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, EXEC, OUT_WAIT.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch cmd_word into cmd_q and go to EXEC.
- EXEC (one cycle, cmd_ready=0): decode cmd_q.
  - ID=BANK (4'b0000), [7:4]==0, [27:16]==0: for each i with en[i]=1, bank_val[i] <= cmd_q[15:8]; bank_upd <= en. Go to IDLE. en==0 is legal and is a no-op write with bank_upd=0.
  - ID=OUT (4'b0001), [27:5]==0: out_code <= cmd_q[4:0], out_valid <= 1. Go to OUT_WAIT.
  - Any other ID, or nonzero reserved bits: err_pulse <= 1, err_cnt <= err_cnt+1, saturating at all-ones. Banks and out_code are unchanged. Go to IDLE.
- OUT_WAIT: hold out_valid=1 and out_code stable. On out_ready, clear out_valid and go to IDLE. out_code holds its last value after the handshake.
- Only one command is in flight, so banks never change while an OUT is pending.
- Reset values: state=IDLE, cmd_ready=1, bank_val=0, bank_upd=0, out_valid=0, out_code=0, err_pulse=0, err_cnt=0, busy=0.

## Timing
- Accept at edge N. The EXEC decision registers at edge N+1, so bank_val, bank_upd, out_valid and err_pulse are visible after edge N+1.
- cmd_ready falls after edge N. It returns after edge N+1 for BANK and error words, giving a peak throughput of one word per 2 cycles. For OUT, cmd_ready returns one cycle after the out handshake edge.
- out_valid may assert with out_ready already high: the handshake completes at edge N+2 and out_valid is high for exactly one cycle.
- out_valid never deasserts without a handshake, except on reset.
- bank_upd and err_pulse are high for exactly one cycle per command.
- Reset mid-operation, any state: immediate asynchronous return to reset values. The in-flight word is dropped and is not counted as an error.

## Structure
- Shared cmd_icd_pkg gains:
  - cmd_word_t packed struct overlay (id, body) with bank and out views.
  - NUM_BANKS=4 and BANK_VAL_W=8.
  - A function bank_word_ok()/out_word_ok() for reserved-bit checks.
- The FSM state enum stays local to the module.
- One combinational sub-module, cmd_word_decode, takes the 32-bit word and produces is_bank, is_out, is_err, en[3:0], val[7:0] and code[4:0]. The FSM, bank registers and counter live in cmd_dispatcher.

## Test plan
- Bank write: word 0x0000_A505 → next cycle bank0=0xA5, bank2=0xA5, banks 1 and 3 = 0, bank_upd=4'b0101 for 1 cycle, no error.
- Output with backpressure: word 0x1000_0013 with out_ready low for 5 cycles → out_valid high with out_code=0x13 held 5 cycles, cmd_ready low throughout; out_ready=1 → out_valid drops and cmd_ready returns the following cycle.
- Bad ID and reserved bits:
  - 0x2000_0000 → err_pulse once, err_cnt=1.
  - 0x0000_A5F5 (bits [7:4] nonzero) → err_cnt=2, banks unchanged.
  - 0x1000_0020 (bit 5 set) → err_cnt=3, no out_valid.
- Saturation: 300 bad words with ERR_CNT_W=8 → err_cnt stops at 255, err_pulse still fires for each word.
- Back-to-back stream with cmd_valid held high: BANK 0x0000_110F, OUT 0x1000_0001, BANK 0x0000_2208, out_ready=1 → accepts 2 cycles apart except after OUT; final banks = 0x11, 0x11, 0x11, 0x22; out_code=0x01 seen once.
- Reset mid-OUT: deassert rst_n during OUT_WAIT → out_valid=0, banks=0, err_cnt=0 immediately; after release cmd_ready=1 and the next word is processed normally.
